// File: rtl/div_pkg_lzh.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t   : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   DIV_N_DEFAULT : default divisor/remainder width
//   cnt_width()   : width of the step counter for a given N (counts 0..2N-1)
package div_pkg_lzh;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam int DIV_N_DEFAULT = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(2 * n) : 1;
    endfunction

endpackage

// File: rtl/div_step_lzh.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_in   [N-1:0]  partial remainder before the step (always < divisor)
//   dvd_bit           next dividend bit shifted in at the LSB
//   divisor  [N-1:0]  divisor
//   rem_out  [N-1:0]  partial remainder after the step
//   q_bit             quotient bit produced by this step
module div_step_lzh
    import div_pkg_lzh::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N-1:0] rem_in,
    input  logic         dvd_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] trial;

    // Shifted remainder needs N+1 bits: it can reach 2*divisor-1.
    assign shifted = {rem_in, dvd_bit};

    // Trial subtraction as x + ~y + 1 over N+1 bits. Because shifted < 2*divisor,
    // trial[N] is set exactly when shifted < divisor (the borrow case).
    assign trial = shifted + ~{1'b0, divisor} + {{N{1'b0}}, 1'b1};

    assign q_bit = ~trial[N];

    // When the trial fails, shifted < divisor < 2^N, so dropping its MSB loses nothing.
    assign rem_out = q_bit ? trial[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/seq_divider_lzh.sv
// Unsigned sequential restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock.
// Handshake: start is sampled only in IDLE; an accepted operation raises busy
// for 2N cycles and then pulses done for one cycle with the results valid.
// Results stay held until the next accept. start in RUN/DONE is dropped.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request, sampled only in IDLE
//   dividend [2N-1:0]   operand, latched on the accepting edge
//   divisor  [N-1:0]    operand, latched on the accepting edge
//   busy                high while in RUN
//   done                one-cycle pulse when results are valid
//   quotient [2N-1:0]   held result
//   remainder[N-1:0]    held result
//   div_zero            held result was a divide by zero
//   dbg_state           current FSM state (observation only)
module seq_divider_lzh
    import div_pkg_lzh::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2*N-1:0]  dividend,
    input  logic [N-1:0]    divisor,
    output logic            busy,
    output logic            done,
    output logic [2*N-1:0]  quotient,
    output logic [N-1:0]    remainder,
    output logic            div_zero,
    output div_state_t      dbg_state
);

    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);

    div_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]      dsr_q, dsr_d;
    logic [N-1:0]      rem_q, rem_d;
    logic [2*N-1:0]    qsh_q, qsh_d;
    logic [2*N-1:0]    quot_q, quot_d;
    logic [N-1:0]      remo_q, remo_d;
    logic              dz_q, dz_d;

    logic [N-1:0]      step_rem;
    logic              step_q;

    div_step_lzh #(.N(N)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[2*N-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    qsh_d   = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        // Divide by zero bypasses RUN and reports immediately.
                        state_d = S_DONE;
                        quot_d  = '1;
                        remo_d  = dividend[N-1:0];
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                rem_d   = step_rem;
                dvd_d   = {dvd_q[2*N-2:0], 1'b0};
                qsh_d   = {qsh_q[2*N-2:0], step_q};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Final step: publish the result straight from this step's outputs.
                    state_d = S_DONE;
                    quot_d  = {qsh_q[2*N-2:0], step_q};
                    remo_d  = step_rem;
                    dz_d    = 1'b0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule
